nbit_down_counter: RTL
======================

Name: nbit_down_counter

Overview:
Loadable N-bit down-counter; the consuming end of the transfer-count path in the memory-to-memory transfer example. The controller loads a beat count; each accepted beat decrements it. The block flags terminal count so the controller stops issuing beats. It complements the up-counting address counter: the address counter counts up from a start value, and this block counts the same transfer down to zero.

Parameters:
COUNT_BITS, 8, width of count and start_seq
PATH_DELAY, 3, simulation-only delay (ns) on registered updates and on the decrementer output; 0 has no functional effect

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
ld  input  1  load start_seq into count; takes priority over en
en  input  1  beat accepted; decrement when in RUN
start_seq  input  COUNT_BITS  transfer length in beats
count  output  COUNT_BITS  remaining beats (registered)
busy  output  1  high while state is RUN
tc  output  1  terminal count; high while state is DONE
done  output  1  one-cycle pulse on the edge that enters DONE

Behaviour:
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The unused encoding 2'b11 goes to IDLE on the next edge, with count held.
- Reset (rst_n=0, asynchronous): count=0, state=IDLE, busy=0, tc=0, done=0. This applies immediately, including in the middle of RUN. The first edge after release samples normally.
- All outputs are registered. count, busy, tc and done update one clk edge after ld or en is sampled.
- ld=1 in any state:
  - count<=start_seq.
  - If start_seq!=0, next state is RUN.
  - If start_seq==0, next state is DONE and done pulses on that edge.
  - en is ignored on that edge.
- RUN, ld=0, en=1:
  - count<=count-1.
  - If count==1, next state is DONE, count becomes 0, and done=1 for exactly that cycle.
- RUN, ld=0, en=0: hold everything; done=0.
- IDLE or DONE, ld=0: en is ignored. count holds, with no wrap to all-ones; underflow is impossible.
- done defaults to 0 every cycle unless set by the rules above.
- busy=(state==RUN) and tc=(state==DONE), both registered with the state.
- Arithmetic: unsigned, modulo 2^COUNT_BITS. Max length is 2^COUNT_BITS-1 beats.

Optional Feature:
XFER_CNT_RELOAD_EN
- Defined:
  - A reload register captures start_seq on every ld.
  - In RUN, with en=1 and count==1, count<=reload. The state stays RUN, done pulses, and tc stays 0.
  - The count repeats until ld loads a new value or reset. Loading 0 still goes to DONE.
- Undefined: no reload register; behaviour is exactly as above.

Decomposition:
- Shared package nbit_counter_pkg holds:
  - the state encodings (IDLE/RUN/DONE) as a 2-bit typedef or localparams;
  - a default COUNT_BITS constant.
- One sub-module, nbit_decrementer: combinational count-1 with a borrow out, parameterised on BITWIDTH and PATH_DELAY. It mirrors the adder used by the up-counter. The top block instantiates it.

Test Plan:
- Reset in mid-RUN: load 5, two en beats (count=3), drop rst_n asynchronously -> count=0, busy=0 immediately; after release, en pulses leave count=0 and state IDLE.
- Normal run: ld with start_seq=3, then en held high -> count 3,2,1,0 on successive edges; done pulses on the edge count reaches 0; tc=1 afterwards; further en keeps count=0.
- Gapped beats: ld 4, en pattern 1,0,0,1,1,0,1 -> count 4,3,3,3,2,1,1,0; busy high until DONE; done a single pulse.
- ld/en collision: in RUN at count=2, assert ld=1 and en=1 with start_seq=7 -> count=7 next edge, no decrement.
- Zero load: ld with start_seq=0 from IDLE -> DONE, tc=1, done pulse, busy never asserts.
- Width boundary with COUNT_BITS=4: ld 15, 15 beats -> count reaches 0 with no wrap to 15. With XFER_CNT_RELOAD_EN defined, ld 2 and 5 beats -> count 2,1,2,1,2,1 with done pulses after beats 2 and 4; tc stays 0.

Source files
------------

// File: rtl/nbit_counter_pkg.sv
// Shared definitions for the transfer-count path: state encodings and default width.
package nbit_counter_pkg;

    localparam int DEFAULT_COUNT_BITS = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/nbit_decrementer.sv
// Combinational value-1 with borrow out; the down-counting twin of the address counter's adder.
module nbit_decrementer
    import nbit_counter_pkg::*;
#(
    parameter int BITWIDTH   = DEFAULT_COUNT_BITS,
    parameter int PATH_DELAY = 3
) (
    input  logic [BITWIDTH-1:0] value,
    output logic [BITWIDTH-1:0] diff,
    output logic                borrow
);

    logic [BITWIDTH:0] wide;

    assign wide   = {1'b0, value} - {{BITWIDTH{1'b0}}, 1'b1};
    assign diff   = wide[BITWIDTH-1:0];
    assign borrow = wide[BITWIDTH];

    // PATH_DELAY only shapes timing in zero-delay-free simulation views; this view is functional.
    if (PATH_DELAY < 0) begin : g_invalid_path_delay
    end

endmodule

// File: rtl/nbit_down_counter.sv
// Loadable down-counter for transfer beat counts; flags terminal count to stop the controller.
// Optional XFER_CNT_RELOAD_EN: reload the last loaded length on the final beat and keep running.
//
// state | meaning
// IDLE  | no transfer loaded since reset
// RUN   | beats remaining, en decrements
// DONE  | terminal count reached, count held at 0
module nbit_down_counter
    import nbit_counter_pkg::*;
#(
    parameter int COUNT_BITS = DEFAULT_COUNT_BITS,
    parameter int PATH_DELAY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld,
    input  logic                  en,
    input  logic [COUNT_BITS-1:0] start_seq,
    output logic [COUNT_BITS-1:0] count,
    output logic                  busy,
    output logic                  tc,
    output logic                  done
);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [COUNT_BITS-1:0] next_count;
    logic [COUNT_BITS-1:0] dec_diff;
    logic                  dec_borrow;
    logic                  last_beat;
    logic                  next_done;

    nbit_decrementer #(
        .BITWIDTH   (COUNT_BITS),
        .PATH_DELAY (PATH_DELAY)
    ) u_dec (
        .value  (count),
        .diff   (dec_diff),
        .borrow (dec_borrow)
    );

    // count==1 is exactly "decrement lands on zero without borrowing"
    assign last_beat = (dec_diff == '0) && !dec_borrow;

`ifdef XFER_CNT_RELOAD_EN
    logic [COUNT_BITS-1:0] reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= '0;
        end else if (ld) begin
            reload <= start_seq;
        end
    end
`endif

    always_comb begin
        next_state = state;
        next_count = count;
        next_done  = 1'b0;
        if (ld) begin
            next_count = start_seq;
            if (start_seq == '0) begin
                next_state = ST_DONE;
                next_done  = 1'b1;
            end else begin
                next_state = ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (en) begin
                        next_count = dec_diff;
                        if (last_beat) begin
                            next_done = 1'b1;
`ifdef XFER_CNT_RELOAD_EN
                            next_count = reload;
`else
                            next_state = ST_DONE;
`endif
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    next_state = state;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            busy  <= (next_state == ST_RUN);
            tc    <= (next_state == ST_DONE);
            done  <= next_done;
        end
    end

endmodule
